// File: rtl/t06_tick_sequencer_if.sv
// Request/done handshake bundle between the tick sequencer and the move,
// check, grow and draw engines.
interface t06_tick_sequencer_if;
    logic move_req;
    logic move_done;
    logic check_req;
    logic check_done;
    logic collision;
    logic apple;
    logic grow_req;
    logic grow_done;
    logic draw_req;
    logic draw_done;

    modport master (
        output move_req, check_req, grow_req, draw_req,
        input  move_done, check_done, collision, apple, grow_done, draw_done
    );

    modport slave (
        input  move_req, check_req, grow_req, draw_req,
        output move_done, check_done, collision, apple, grow_done, draw_done
    );
endinterface

// File: rtl/t06_tick_sequencer.sv
// Game-tick sequencer: runs MOVE -> CHECK -> (GROW) -> DRAW per body tick,
// with per-phase timeout, one-deep tick buffering and saturating counters.
module t06_tick_sequencer #(
    parameter int TIMEOUT = 1023,
    parameter int SCORE_W = 8
) (
    input  logic                 system_clk,
    input  logic                 nreset,
    input  logic [1:0]           game_state,
    input  logic                 body_tick,
    t06_tick_sequencer_if.master hs,
    output logic                 busy,
    output logic                 game_over,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           overrun_cnt,
    output logic                 timeout_err
);
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, MOVE, CHECK, GROW, DRAW} state_t;

    state_t               state, state_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic                 pending, pending_nxt;
    logic [SCORE_W-1:0]   score_nxt;
    logic [3:0]           overrun_nxt;
    logic                 timeout_nxt;
    logic                 game_over_nxt;
    logic                 running;
    logic                 phase_done;

    assign running = (game_state == 2'b00);

    always_comb begin
        phase_done = 1'b0;
        case (state)
            MOVE:    phase_done = hs.move_done;
            CHECK:   phase_done = hs.check_done;
            GROW:    phase_done = hs.grow_done;
            DRAW:    phase_done = hs.draw_done;
            default: phase_done = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer + 1'b1;
        pending_nxt   = pending;
        score_nxt     = score;
        overrun_nxt   = overrun_cnt;
        timeout_nxt   = timeout_err;
        game_over_nxt = 1'b0;

        if (!running) begin
            state_nxt   = IDLE;
            timer_nxt   = '0;
            pending_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer_nxt = '0;
                    if (body_tick || pending) begin
                        state_nxt = MOVE;
                        // a fresh tick arriving while a buffered one launches stays buffered
                        pending_nxt = pending && body_tick;
                    end
                end
                MOVE:  if (hs.move_done) state_nxt = CHECK;
                CHECK: begin
                    if (hs.check_done) begin
                        if (hs.collision) begin
                            state_nxt     = IDLE;
                            game_over_nxt = 1'b1;
                        end else if (hs.apple) begin
                            state_nxt = GROW;
                            if (score != '1) score_nxt = score + 1'b1;
                        end else begin
                            state_nxt = DRAW;
                        end
                    end
                end
                GROW:    if (hs.grow_done) state_nxt = DRAW;
                DRAW:    if (hs.draw_done) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase

            if (state != IDLE && !phase_done && timer == TIMER_LAST) begin
                state_nxt   = IDLE;
                timeout_nxt = 1'b1;
            end

            if (state_nxt != state) timer_nxt = '0;

            if (state != IDLE && body_tick) begin
                if (!pending)
                    pending_nxt = 1'b1;
                else if (overrun_cnt != 4'hF)
                    overrun_nxt = overrun_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (!nreset) begin
            state       <= IDLE;
            timer       <= '0;
            pending     <= 1'b0;
            score       <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            pending     <= pending_nxt;
            score       <= score_nxt;
            overrun_cnt <= overrun_nxt;
            timeout_err <= timeout_nxt;
            game_over   <= game_over_nxt;
        end
    end

    assign hs.move_req  = (state == MOVE);
    assign hs.check_req = (state == CHECK);
    assign hs.grow_req  = (state == GROW);
    assign hs.draw_req  = (state == DRAW);
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_t06_tick_sequencer.sv
// Bench for t06_tick_sequencer: directed phase traces plus randomized
// sequences checked against a phase-list model.
module tb_t06_tick_sequencer;
    localparam int TB_TIMEOUT = 40;
    localparam int TB_SCORE_W = 8;

    logic                  system_clk;
    logic                  nreset;
    logic [1:0]            game_state;
    logic                  body_tick;
    logic                  busy;
    logic                  game_over;
    logic [TB_SCORE_W-1:0] score;
    logic [3:0]            overrun_cnt;
    logic                  timeout_err;

    int n_cmp;
    int n_bad;

    t06_tick_sequencer_if hs();

    t06_tick_sequencer #(
        .TIMEOUT (TB_TIMEOUT),
        .SCORE_W (TB_SCORE_W)
    ) dut (
        .system_clk  (system_clk),
        .nreset      (nreset),
        .game_state  (game_state),
        .body_tick   (body_tick),
        .hs          (hs),
        .busy        (busy),
        .game_over   (game_over),
        .score       (score),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    initial begin
        system_clk = 1'b0;
        forever #5 system_clk = ~system_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // one cycle of a directed trace: expected {move,check,grow,draw,busy},
    // expected game_over, then inputs to drive for the next edge
    typedef struct packed {
        logic [4:0] ex;
        logic       go;
        logic       tick;
        logic [1:0] gs;
        logic [3:0] dn;
        logic       col;
        logic       app;
    } step_t;

    function automatic logic [4:0] req_vec();
        return {hs.move_req, hs.check_req, hs.grow_req, hs.draw_req, busy};
    endfunction

    task automatic next_cycle();
        @(negedge system_clk);
    endtask

    task automatic drive(input logic tick, input logic [1:0] gs, input logic [3:0] dn,
                         input logic col, input logic app);
        body_tick  = tick;
        game_state = gs;
        {hs.move_done, hs.check_done, hs.grow_done, hs.draw_done} = dn;
        hs.collision = col;
        hs.apple     = app;
    endtask

    task automatic respond();
        {hs.move_done, hs.check_done, hs.grow_done, hs.draw_done} =
            {hs.move_req, hs.check_req, hs.grow_req, hs.draw_req};
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
        nreset = 1'b0;
        next_cycle();
        next_cycle();
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (req_vec() !== 5'b00000) begin
            n_bad++; $display("FAIL reset_reqs: got %b want 00000", req_vec());
        end
        n_cmp++;
        if ({game_over, timeout_err, overrun_cnt} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got go=%b terr=%b ovr=%0d want 0", game_over, timeout_err, overrun_cnt);
        end
        n_cmp++;
        if (score !== '0) begin
            n_bad++; $display("FAIL reset_score: got %0d want 0", score);
        end
    endtask

    task automatic test_basic();
        step_t tr [6] = '{
            '{5'b00000, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b0, 2'b00, 4'b1011, 1'b0, 1'b0},
            '{5'b01001, 1'b0, 1'b0, 2'b00, 4'b0101, 1'b0, 1'b0},
            '{5'b00011, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}
        };
        foreach (tr[c]) begin
            n_cmp++;
            if (req_vec() !== tr[c].ex) begin
                n_bad++; $display("FAIL basic_trace c%0d: got %b want %b", c, req_vec(), tr[c].ex);
            end
            n_cmp++;
            if (game_over !== tr[c].go) begin
                n_bad++; $display("FAIL basic_game_over c%0d: got %b want %b", c, game_over, tr[c].go);
            end
            drive(tr[c].tick, tr[c].gs, tr[c].dn, tr[c].col, tr[c].app);
            next_cycle();
        end
        n_cmp++;
        if (score !== 8'd0) begin
            n_bad++; $display("FAIL basic_score: got %0d want 0", score);
        end
    endtask

    task automatic test_apple();
        step_t tr [7] = '{
            '{5'b00000, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0},
            '{5'b01001, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b1},
            '{5'b00101, 1'b0, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0},
            '{5'b00011, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}
        };
        foreach (tr[c]) begin
            n_cmp++;
            if (req_vec() !== tr[c].ex) begin
                n_bad++; $display("FAIL apple_trace c%0d: got %b want %b", c, req_vec(), tr[c].ex);
            end
            drive(tr[c].tick, tr[c].gs, tr[c].dn, tr[c].col, tr[c].app);
            next_cycle();
        end
        n_cmp++;
        if (score !== 8'd1) begin
            n_bad++; $display("FAIL apple_score: got %0d want 1", score);
        end
    endtask

    task automatic test_collision();
        step_t tr [6] = '{
            '{5'b00000, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0},
            '{5'b01001, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b1, 1'b1},
            '{5'b00000, 1'b1, 1'b0, 2'b00, 4'b0011, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}
        };
        foreach (tr[c]) begin
            n_cmp++;
            if (req_vec() !== tr[c].ex) begin
                n_bad++; $display("FAIL collision_trace c%0d: got %b want %b", c, req_vec(), tr[c].ex);
            end
            n_cmp++;
            if (game_over !== tr[c].go) begin
                n_bad++; $display("FAIL collision_game_over c%0d: got %b want %b", c, game_over, tr[c].go);
            end
            drive(tr[c].tick, tr[c].gs, tr[c].dn, tr[c].col, tr[c].app);
            next_cycle();
        end
        n_cmp++;
        if (score !== 8'd1) begin
            n_bad++; $display("FAIL collision_score: got %0d want 1", score);
        end
    endtask

    task automatic test_saturation();
        int exp_sc = 1;
        for (int n = 0; n < 300; n++) begin
            int g = 0;
            drive(1'b1, 2'b00, 4'b0000, 1'b0, 1'b1);
            next_cycle();
            body_tick = 1'b0;
            while (busy === 1'b1 && g < 12) begin
                respond();
                next_cycle();
                g++;
            end
            drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
            exp_sc = (exp_sc < 255) ? exp_sc + 1 : 255;
            n_cmp++;
            if (g == 0 || g >= 12) begin
                n_bad++; $display("FAIL sat_sequence n%0d: busy cycles %0d want 1..11", n, g);
            end
            n_cmp++;
            if (score !== 8'(exp_sc)) begin
                n_bad++; $display("FAIL sat_score n%0d: got %0d want %0d", n, score, exp_sc);
            end
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        int g = 0;
        drive(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 2'b00, 4'b0101, 1'b1, 1'b1);
        while (hs.move_req === 1'b1 && cnt < TB_TIMEOUT + 10) begin
            cnt++;
            next_cycle();
        end
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
        n_cmp++;
        if (cnt != TB_TIMEOUT) begin
            n_bad++; $display("FAIL timeout_len: move_req high %0d cycles want %0d", cnt, TB_TIMEOUT);
        end
        n_cmp++;
        if ({busy, timeout_err} !== 2'b01) begin
            n_bad++; $display("FAIL timeout_state: got busy=%b terr=%b want busy=0 terr=1", busy, timeout_err);
        end
        drive(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0);
        next_cycle();
        body_tick = 1'b0;
        while (busy === 1'b1 && g < 12) begin
            respond();
            next_cycle();
            g++;
        end
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
        n_cmp++;
        if (g != 3) begin
            n_bad++; $display("FAIL timeout_recover: busy %0d cycles want 3", g);
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        end
    endtask

    task automatic test_overrun();
        step_t tr [12] = '{
            '{5'b00000, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b0, 1'b0},
            '{5'b01001, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0},
            '{5'b00011, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b0},
            '{5'b01001, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b0},
            '{5'b00011, 1'b0, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}
        };
        do_reset();
        foreach (tr[c]) begin
            n_cmp++;
            if (req_vec() !== tr[c].ex) begin
                n_bad++; $display("FAIL overrun_trace c%0d: got %b want %b", c, req_vec(), tr[c].ex);
            end
            drive(tr[c].tick, tr[c].gs, tr[c].dn, tr[c].col, tr[c].app);
            next_cycle();
        end
        n_cmp++;
        if (overrun_cnt !== 4'd2) begin
            n_bad++; $display("FAIL overrun_count: got %0d want 2", overrun_cnt);
        end
        // 16 more ticks in one MOVE phase: first buffers, 15 drop -> saturates
        drive(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0);
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            body_tick = 1'b1;
            next_cycle();
        end
        body_tick = 1'b0;
        for (int s = 0; s < 2; s++) begin
            int g = 0;
            while (busy === 1'b1 && g < 12) begin
                respond();
                next_cycle();
                g++;
            end
            drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
            n_cmp++;
            if (g == 0 || g >= 12) begin
                n_bad++; $display("FAIL overrun_seq s%0d: busy cycles %0d want 1..11", s, g);
            end
            if (s == 0) next_cycle();
        end
        n_cmp++;
        if (overrun_cnt !== 4'd15) begin
            n_bad++; $display("FAIL overrun_saturate: got %0d want 15", overrun_cnt);
        end
    endtask

    task automatic test_abort_grow();
        step_t tr [8] = '{
            '{5'b00000, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b0, 1'b0},
            '{5'b01001, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b1},
            '{5'b00101, 1'b0, 1'b1, 2'b01, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b1, 2'b11, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b00000, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}
        };
        do_reset();
        foreach (tr[c]) begin
            n_cmp++;
            if (req_vec() !== tr[c].ex) begin
                n_bad++; $display("FAIL abort_trace c%0d: got %b want %b", c, req_vec(), tr[c].ex);
            end
            drive(tr[c].tick, tr[c].gs, tr[c].dn, tr[c].col, tr[c].app);
            next_cycle();
        end
        n_cmp++;
        if ({score, overrun_cnt} !== {8'd1, 4'd0}) begin
            n_bad++; $display("FAIL abort_counters: got score=%0d ovr=%0d want 1/0", score, overrun_cnt);
        end
    endtask

    task automatic test_reset_mid_draw();
        step_t tr [6] = '{
            '{5'b00000, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0},
            '{5'b10001, 1'b0, 1'b1, 2'b00, 4'b1000, 1'b0, 1'b0},
            '{5'b01001, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, 1'b1},
            '{5'b00101, 1'b0, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0},
            '{5'b00011, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}
        };
        do_reset();
        foreach (tr[c]) begin
            n_cmp++;
            if (req_vec() !== tr[c].ex) begin
                n_bad++; $display("FAIL rstdraw_trace c%0d: got %b want %b", c, req_vec(), tr[c].ex);
            end
            drive(tr[c].tick, tr[c].gs, tr[c].dn, tr[c].col, tr[c].app);
            next_cycle();
        end
        n_cmp++;
        if ({hs.draw_req, score, overrun_cnt} !== {1'b1, 8'd1, 4'd1}) begin
            n_bad++; $display("FAIL rstdraw_pre: got draw=%b score=%0d ovr=%0d want 1/1/1", hs.draw_req, score, overrun_cnt);
        end
        nreset = 1'b0;
        drive(1'b1, 2'b00, 4'b0001, 1'b0, 1'b0);
        next_cycle();
        n_cmp++;
        if ({req_vec(), game_over, score, overrun_cnt, timeout_err} !== 19'b0) begin
            n_bad++; $display("FAIL rstdraw_post: got reqs=%b go=%b score=%0d ovr=%0d terr=%b want all 0",
                              req_vec(), game_over, score, overrun_cnt, timeout_err);
        end
        nreset = 1'b1;
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++; $display("FAIL rstdraw_pending i%0d: got busy=%b want 0", i, busy);
            end
        end
    endtask

    task automatic test_random(input int iters);
        int  sc = 0;
        int  ov = 0;
        bit  pend = 1'b0;
        bit  prev_co = 1'b0;
        do_reset();
        for (int it = 0; it < iters; it++) begin
            int          ph[$];
            logic [15:0] tmask;
            int          k, gap, idx;
            bit          co, ap;
            ph.delete();
            tmask = '0;
            co = ($urandom_range(0, 4) == 0);
            ap = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 4)) ph.push_back(1);
            repeat ($urandom_range(1, 4)) ph.push_back(2);
            if (!co) begin
                if (ap) repeat ($urandom_range(1, 4)) ph.push_back(3);
                repeat ($urandom_range(1, 4)) ph.push_back(4);
            end
            k = $urandom_range(0, 5);
            if (k > 3) k = 0;
            if (k > ph.size()) k = ph.size();
            if (it == iters - 1) k = 0;
            for (int t = 0; t < k; t++) begin
                idx = $urandom_range(0, ph.size() - 1);
                while (tmask[idx]) idx = (idx + 1) % ph.size();
                tmask[idx] = 1'b1;
            end
            gap = pend ? 0 : $urandom_range(0, 2);

            for (int g = 0; g <= gap; g++) begin
                n_cmp++;
                if (req_vec() !== 5'b00000 || game_over !== (g == 0 && prev_co)) begin
                    n_bad++; $display("FAIL rand_idle it%0d g%0d: got reqs=%b go=%b want 00000 go=%b",
                                      it, g, req_vec(), game_over, (g == 0 && prev_co));
                end
                n_cmp++;
                if (score !== 8'(sc) || overrun_cnt !== 4'(ov)) begin
                    n_bad++; $display("FAIL rand_counters it%0d: got score=%0d ovr=%0d want %0d/%0d",
                                      it, score, overrun_cnt, sc, ov);
                end
                drive(!pend && g == gap, 2'b00, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                next_cycle();
            end

            for (int i = 0; i < ph.size(); i++) begin
                bit last;
                n_cmp++;
                if (req_vec() !== {ph[i] == 1, ph[i] == 2, ph[i] == 3, ph[i] == 4, 1'b1} || game_over !== 1'b0) begin
                    n_bad++; $display("FAIL rand_phase it%0d i%0d: got reqs=%b go=%b want phase %0d",
                                      it, i, req_vec(), game_over, ph[i]);
                end
                last = (i == ph.size() - 1) || (ph[i + 1] != ph[i]);
                body_tick     = tmask[i];
                hs.move_done  = (ph[i] == 1) ? last : 1'($urandom_range(0, 1));
                hs.check_done = (ph[i] == 2) ? last : 1'($urandom_range(0, 1));
                hs.grow_done  = (ph[i] == 3) ? last : 1'($urandom_range(0, 1));
                hs.draw_done  = (ph[i] == 4) ? last : 1'($urandom_range(0, 1));
                hs.collision  = (ph[i] == 2 && last) ? co : 1'($urandom_range(0, 1));
                hs.apple      = (ph[i] == 2 && last) ? ap : 1'($urandom_range(0, 1));
                next_cycle();
            end
            body_tick = 1'b0;

            if (!co && ap && sc < 255) sc++;
            if (k > 1) ov = (ov + k - 1 > 15) ? 15 : ov + k - 1;
            pend    = (k > 0);
            prev_co = co;
        end
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
        n_cmp++;
        if (req_vec() !== 5'b00000 || game_over !== prev_co || score !== 8'(sc) ||
            overrun_cnt !== 4'(ov) || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL rand_final: got reqs=%b go=%b score=%0d ovr=%0d terr=%b want 00000 go=%b %0d/%0d terr=0",
                              req_vec(), game_over, score, overrun_cnt, timeout_err, prev_co, sc, ov);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        nreset = 1'b0;
        drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_apple();
        test_collision();
        test_saturation();
        test_timeout();
        test_overrun();
        test_abort_grow();
        test_reset_mid_draw();
        test_random(150);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
